// File: rtl/vx_afu_mem_gate.sv
// ---------------------------------------------------------------------------
// vx_afu_mem_gate
//   Per-bank AXI4 master stage between the Vortex core memory port (s_axi_*)
//   and one device memory bank (m_axi_*).
//   - AW/AR: rebased by mem_base at buffer entry, held in 2-entry skid
//     buffers, presented on m_axi_*valid one cycle after the s-side handshake.
//   - W/B/R: combinational pass-through, zero latency.
//   - Outstanding writes/reads are counted and capped; drain stops new AW/AR
//     so the AFU controller can wait on idle before raising ap_done.
// Ports
//   clk, reset            clock, synchronous active-high reset
//   mem_base              bank base address, sampled on AW/AR entry
//   drain                 1 = refuse new AW/AR from the core
//   s_axi_*               core-side AXI4 slave (AW, W, B, AR, R)
//   m_axi_*               memory-side AXI4 master (AW, W, B, AR, R)
//   pending_wr/pending_rd outstanding write / read transactions
//   idle                  nothing outstanding and both buffers empty
//   err, err_id           sticky error response flag and ID of the first one
// ---------------------------------------------------------------------------

// Two-entry request buffer: slot 0 is the presented head, slot 1 the skid.
module vx_afu_mem_gate_skid #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             empty_next
);
    logic             v0_r, v1_r;
    logic [WIDTH-1:0] d0_r, d1_r;
    logic             v0_next_s, v1_next_s;
    logic [WIDTH-1:0] d0_next_s, d1_next_s;
    logic             pop_s;

    assign pop_s      = v0_r & out_ready;
    assign full       = v1_r;
    assign out_valid  = v0_r;
    assign out_data   = d0_r;
    assign empty_next = ~v0_next_s;

    // Next-state of the two slots for every push/pop combination.
    always_comb begin
        v0_next_s = v0_r;
        v1_next_s = v1_r;
        d0_next_s = d0_r;
        d1_next_s = d1_r;
        case ({push, pop_s})
            2'b10: begin
                if (!v0_r) begin
                    v0_next_s = 1'b1;
                    d0_next_s = push_data;
                end else begin
                    v1_next_s = 1'b1;
                    d1_next_s = push_data;
                end
            end
            2'b01: begin
                v0_next_s = v1_r;
                v1_next_s = 1'b0;
                d0_next_s = d1_r;
            end
            2'b11: begin
                // Head leaves; the skid entry (if any) moves up behind it.
                if (v1_r) begin
                    d0_next_s = d1_r;
                    d1_next_s = push_data;
                end else begin
                    d0_next_s = push_data;
                end
            end
            default: begin
                v0_next_s = v0_r;
                v1_next_s = v1_r;
            end
        endcase
    end

    // Slot registers; reset discards anything buffered.
    always_ff @(posedge clk) begin
        if (reset) begin
            v0_r <= 1'b0;
            v1_r <= 1'b0;
            d0_r <= {WIDTH{1'b0}};
            d1_r <= {WIDTH{1'b0}};
        end else begin
            v0_r <= v0_next_s;
            v1_r <= v1_next_s;
            d0_r <= d0_next_s;
            d1_r <= d1_next_s;
        end
    end
endmodule

// Simulation-time protocol checks for the gate.
module vx_afu_mem_gate_chk (
    input logic clk,
    input logic reset,
    input logic wr_inc,
    input logic wr_dec,
    input logic wr_zero,
    input logic rd_inc,
    input logic rd_dec,
    input logic rd_zero,
    input logic aw_valid,
    input logic aw_ready,
    input logic ar_valid,
    input logic ar_ready
);
    // A B response with no write outstanding is a stray response.
    a_wr_underflow: assert property (@(posedge clk) disable iff (reset)
        !(wr_dec && !wr_inc && wr_zero));
    // An RLAST beat with no read outstanding is a stray response.
    a_rd_underflow: assert property (@(posedge clk) disable iff (reset)
        !(rd_dec && !rd_inc && rd_zero));
    // A presented memory-side request stays up until accepted.
    a_aw_hold: assert property (@(posedge clk) disable iff (reset)
        (aw_valid && !aw_ready) |=> aw_valid);
    a_ar_hold: assert property (@(posedge clk) disable iff (reset)
        (ar_valid && !ar_ready) |=> ar_valid);
endmodule

module vx_afu_mem_gate #(
    parameter int IN_ADDR_WIDTH  = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 512,
    parameter int ID_WIDTH       = 16,
    parameter int MAX_PENDING_WR = 64,
    parameter int MAX_PENDING_RD = 64,
    localparam int WR_CTR_WIDTH  = $clog2(MAX_PENDING_WR + 1),
    localparam int RD_CTR_WIDTH  = $clog2(MAX_PENDING_RD + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [63:0]              mem_base,
    input  logic                     drain,
    // core-side write address
    input  logic                     s_axi_awvalid,
    output logic                     s_axi_awready,
    input  logic [IN_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [ID_WIDTH-1:0]      s_axi_awid,
    // core-side write data
    input  logic                     s_axi_wvalid,
    output logic                     s_axi_wready,
    input  logic [DATA_WIDTH-1:0]    s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]  s_axi_wstrb,
    input  logic                     s_axi_wlast,
    // core-side write response
    output logic                     s_axi_bvalid,
    input  logic                     s_axi_bready,
    output logic [ID_WIDTH-1:0]      s_axi_bid,
    output logic [1:0]               s_axi_bresp,
    // core-side read address
    input  logic                     s_axi_arvalid,
    output logic                     s_axi_arready,
    input  logic [IN_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [ID_WIDTH-1:0]      s_axi_arid,
    input  logic [7:0]               s_axi_arlen,
    // core-side read data
    output logic                     s_axi_rvalid,
    input  logic                     s_axi_rready,
    output logic [DATA_WIDTH-1:0]    s_axi_rdata,
    output logic                     s_axi_rlast,
    output logic [ID_WIDTH-1:0]      s_axi_rid,
    output logic [1:0]               s_axi_rresp,
    // memory-side write address
    output logic                     m_axi_awvalid,
    input  logic                     m_axi_awready,
    output logic [ADDR_WIDTH-1:0]    m_axi_awaddr,
    output logic [ID_WIDTH-1:0]      m_axi_awid,
    output logic [7:0]               m_axi_awlen,
    // memory-side write data
    output logic                     m_axi_wvalid,
    input  logic                     m_axi_wready,
    output logic [DATA_WIDTH-1:0]    m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]  m_axi_wstrb,
    output logic                     m_axi_wlast,
    // memory-side write response
    input  logic                     m_axi_bvalid,
    output logic                     m_axi_bready,
    input  logic [ID_WIDTH-1:0]      m_axi_bid,
    input  logic [1:0]               m_axi_bresp,
    // memory-side read address
    output logic                     m_axi_arvalid,
    input  logic                     m_axi_arready,
    output logic [ADDR_WIDTH-1:0]    m_axi_araddr,
    output logic [ID_WIDTH-1:0]      m_axi_arid,
    output logic [7:0]               m_axi_arlen,
    // memory-side read data
    input  logic                     m_axi_rvalid,
    output logic                     m_axi_rready,
    input  logic [DATA_WIDTH-1:0]    m_axi_rdata,
    input  logic                     m_axi_rlast,
    input  logic [ID_WIDTH-1:0]      m_axi_rid,
    input  logic [1:0]               m_axi_rresp,
    // status
    output logic [WR_CTR_WIDTH-1:0]  pending_wr,
    output logic [RD_CTR_WIDTH-1:0]  pending_rd,
    output logic                     idle,
    output logic                     err,
    output logic [ID_WIDTH-1:0]      err_id
);
    localparam int AW_W = ID_WIDTH + ADDR_WIDTH;
    localparam int AR_W = 8 + ID_WIDTH + ADDR_WIDTH;

    logic                    aw_full_s, ar_full_s;
    logic                    aw_empty_next_s, ar_empty_next_s;
    logic                    aw_fire_s, ar_fire_s, b_fire_s, r_fire_s, r_done_s;
    logic                    b_err_s, r_err_s;
    logic [AW_W-1:0]         aw_push_data_s, aw_out_data_s;
    logic [AR_W-1:0]         ar_push_data_s, ar_out_data_s;
    logic [WR_CTR_WIDTH-1:0] pending_wr_r, pending_wr_next_s;
    logic [RD_CTR_WIDTH-1:0] pending_rd_r, pending_rd_next_s;
    logic                    idle_r, err_r, err_next_s;
    logic [ID_WIDTH-1:0]     err_id_r, err_id_next_s;

    // Upper mem_base bits beyond the memory address width do not take part.
    generate
        if (ADDR_WIDTH < 64) begin : g_base_unused
            logic unused_base_s;
            assign unused_base_s = ^mem_base[63:ADDR_WIDTH];
        end
    endgenerate

    // Ready depends only on registered state and drain, never on valid.
    assign s_axi_awready = ~aw_full_s & ~drain
                         & (pending_wr_r != WR_CTR_WIDTH'(MAX_PENDING_WR));
    assign s_axi_arready = ~ar_full_s & ~drain
                         & (pending_rd_r != RD_CTR_WIDTH'(MAX_PENDING_RD));

    assign aw_fire_s = s_axi_awvalid & s_axi_awready;
    assign ar_fire_s = s_axi_arvalid & s_axi_arready;
    assign b_fire_s  = m_axi_bvalid & s_axi_bready;
    assign r_fire_s  = m_axi_rvalid & s_axi_rready;
    assign r_done_s  = r_fire_s & m_axi_rlast;

    // Rebase wraps modulo 2^ADDR_WIDTH by construction of the sum width.
    assign aw_push_data_s = {s_axi_awid,
                             ADDR_WIDTH'(s_axi_awaddr) + ADDR_WIDTH'(mem_base)};
    assign ar_push_data_s = {s_axi_arlen, s_axi_arid,
                             ADDR_WIDTH'(s_axi_araddr) + ADDR_WIDTH'(mem_base)};

    vx_afu_mem_gate_skid #(.WIDTH(AW_W)) u_aw_buf (
        .clk        (clk),
        .reset      (reset),
        .push       (aw_fire_s),
        .push_data  (aw_push_data_s),
        .full       (aw_full_s),
        .out_valid  (m_axi_awvalid),
        .out_data   (aw_out_data_s),
        .out_ready  (m_axi_awready),
        .empty_next (aw_empty_next_s)
    );

    vx_afu_mem_gate_skid #(.WIDTH(AR_W)) u_ar_buf (
        .clk        (clk),
        .reset      (reset),
        .push       (ar_fire_s),
        .push_data  (ar_push_data_s),
        .full       (ar_full_s),
        .out_valid  (m_axi_arvalid),
        .out_data   (ar_out_data_s),
        .out_ready  (m_axi_arready),
        .empty_next (ar_empty_next_s)
    );

    assign {m_axi_awid, m_axi_awaddr}              = aw_out_data_s;
    assign {m_axi_arlen, m_axi_arid, m_axi_araddr} = ar_out_data_s;
    assign m_axi_awlen = 8'd0;

    // Zero-latency W/B/R channels.
    assign m_axi_wvalid = s_axi_wvalid;
    assign s_axi_wready = m_axi_wready;
    assign m_axi_wdata  = s_axi_wdata;
    assign m_axi_wstrb  = s_axi_wstrb;
    assign m_axi_wlast  = s_axi_wlast;
    assign s_axi_bvalid = m_axi_bvalid;
    assign m_axi_bready = s_axi_bready;
    assign s_axi_bid    = m_axi_bid;
    assign s_axi_bresp  = m_axi_bresp;
    assign s_axi_rvalid = m_axi_rvalid;
    assign m_axi_rready = s_axi_rready;
    assign s_axi_rdata  = m_axi_rdata;
    assign s_axi_rlast  = m_axi_rlast;
    assign s_axi_rid    = m_axi_rid;
    assign s_axi_rresp  = m_axi_rresp;

    // Outstanding counters: simultaneous inc/dec holds, dec at zero saturates.
    always_comb begin
        pending_wr_next_s = pending_wr_r;
        if (aw_fire_s && !b_fire_s) begin
            pending_wr_next_s = pending_wr_r + WR_CTR_WIDTH'(1'b1);
        end else if (!aw_fire_s && b_fire_s && (pending_wr_r != {WR_CTR_WIDTH{1'b0}})) begin
            pending_wr_next_s = pending_wr_r - WR_CTR_WIDTH'(1'b1);
        end else begin
            pending_wr_next_s = pending_wr_r;
        end
        pending_rd_next_s = pending_rd_r;
        if (ar_fire_s && !r_done_s) begin
            pending_rd_next_s = pending_rd_r + RD_CTR_WIDTH'(1'b1);
        end else if (!ar_fire_s && r_done_s && (pending_rd_r != {RD_CTR_WIDTH{1'b0}})) begin
            pending_rd_next_s = pending_rd_r - RD_CTR_WIDTH'(1'b1);
        end else begin
            pending_rd_next_s = pending_rd_r;
        end
    end

    // Sticky error; the first erroring response names err_id, B before R.
    always_comb begin
        b_err_s       = b_fire_s & (m_axi_bresp != 2'b00);
        r_err_s       = r_fire_s & (m_axi_rresp != 2'b00);
        err_next_s    = err_r | b_err_s | r_err_s;
        err_id_next_s = err_id_r;
        if (!err_r && b_err_s) begin
            err_id_next_s = m_axi_bid;
        end else if (!err_r && r_err_s) begin
            err_id_next_s = m_axi_rid;
        end else begin
            err_id_next_s = err_id_r;
        end
    end

    // Status registers; idle is registered from next state so it tracks
    // the counters and buffers exactly with no input-to-output path.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_wr_r <= {WR_CTR_WIDTH{1'b0}};
            pending_rd_r <= {RD_CTR_WIDTH{1'b0}};
            idle_r       <= 1'b1;
            err_r        <= 1'b0;
            err_id_r     <= {ID_WIDTH{1'b0}};
        end else begin
            pending_wr_r <= pending_wr_next_s;
            pending_rd_r <= pending_rd_next_s;
            idle_r       <= (pending_wr_next_s == {WR_CTR_WIDTH{1'b0}})
                          & (pending_rd_next_s == {RD_CTR_WIDTH{1'b0}})
                          & aw_empty_next_s & ar_empty_next_s;
            err_r        <= err_next_s;
            err_id_r     <= err_id_next_s;
        end
    end

    assign pending_wr = pending_wr_r;
    assign pending_rd = pending_rd_r;
    assign idle       = idle_r;
    assign err        = err_r;
    assign err_id     = err_id_r;

    vx_afu_mem_gate_chk u_chk (
        .clk      (clk),
        .reset    (reset),
        .wr_inc   (aw_fire_s),
        .wr_dec   (b_fire_s),
        .wr_zero  (pending_wr_r == {WR_CTR_WIDTH{1'b0}}),
        .rd_inc   (ar_fire_s),
        .rd_dec   (r_done_s),
        .rd_zero  (pending_rd_r == {RD_CTR_WIDTH{1'b0}}),
        .aw_valid (m_axi_awvalid),
        .aw_ready (m_axi_awready),
        .ar_valid (m_axi_arvalid),
        .ar_ready (m_axi_arready)
    );
endmodule

// File: tb/tb_vx_afu_mem_gate.sv
// ---------------------------------------------------------------------------
// tb_vx_afu_mem_gate
//   Directed scenarios followed by a randomized run against a queue-based
//   reference model of the gate (request FIFOs, outstanding counts, sticky
//   error). Prints one summary line: CHECKS <n> ERRORS <n>.
// ---------------------------------------------------------------------------
module tb_vx_afu_mem_gate;
    localparam int DW = 512;
    localparam int IW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, drain;
    logic [63:0] mem_base;
    logic s_axi_awvalid, s_axi_awready;
    logic [31:0] s_axi_awaddr;
    logic [IW-1:0] s_axi_awid;
    logic s_axi_wvalid, s_axi_wready, s_axi_wlast;
    logic [DW-1:0] s_axi_wdata;
    logic [DW/8-1:0] s_axi_wstrb;
    logic s_axi_bvalid, s_axi_bready;
    logic [IW-1:0] s_axi_bid;
    logic [1:0] s_axi_bresp;
    logic s_axi_arvalid, s_axi_arready;
    logic [31:0] s_axi_araddr;
    logic [IW-1:0] s_axi_arid;
    logic [7:0] s_axi_arlen;
    logic s_axi_rvalid, s_axi_rready, s_axi_rlast;
    logic [DW-1:0] s_axi_rdata;
    logic [IW-1:0] s_axi_rid;
    logic [1:0] s_axi_rresp;
    logic m_axi_awvalid, m_axi_awready;
    logic [31:0] m_axi_awaddr;
    logic [IW-1:0] m_axi_awid;
    logic [7:0] m_axi_awlen;
    logic m_axi_wvalid, m_axi_wready, m_axi_wlast;
    logic [DW-1:0] m_axi_wdata;
    logic [DW/8-1:0] m_axi_wstrb;
    logic m_axi_bvalid, m_axi_bready;
    logic [IW-1:0] m_axi_bid;
    logic [1:0] m_axi_bresp;
    logic m_axi_arvalid, m_axi_arready;
    logic [31:0] m_axi_araddr;
    logic [IW-1:0] m_axi_arid;
    logic [7:0] m_axi_arlen;
    logic m_axi_rvalid, m_axi_rready, m_axi_rlast;
    logic [DW-1:0] m_axi_rdata;
    logic [IW-1:0] m_axi_rid;
    logic [1:0] m_axi_rresp;
    logic [6:0] pending_wr, pending_rd;
    logic idle, err;
    logic [IW-1:0] err_id;

    vx_afu_mem_gate dut (
        .clk(clk), .reset(reset), .mem_base(mem_base), .drain(drain),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awid(s_axi_awid),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arid(s_axi_arid), .s_axi_arlen(s_axi_arlen),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rlast(s_axi_rlast),
        .s_axi_rid(s_axi_rid), .s_axi_rresp(s_axi_rresp),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awid(m_axi_awid), .m_axi_awlen(m_axi_awlen),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arid(m_axi_arid), .m_axi_arlen(m_axi_arlen),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rlast(m_axi_rlast),
        .m_axi_rid(m_axi_rid), .m_axi_rresp(m_axi_rresp),
        .pending_wr(pending_wr), .pending_rd(pending_rd),
        .idle(idle), .err(err), .err_id(err_id)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model for the randomized run ----------------
    int          exp_wr, exp_rd;
    logic [47:0] aw_q[$];          // {id, rebased addr} buffered in the gate
    logic [55:0] ar_q[$];          // {len, id, rebased addr}
    logic [15:0] b_q[$];           // write ids accepted by memory, awaiting B
    logic [23:0] r_q[$];           // {id, len} reads accepted by memory
    int          r_left;           // beats left in the burst being returned
    logic [15:0] r_cur_id;
    logic        err_m;
    logic [15:0] err_id_m;
    int          aw_sent, w_sent;
    logic        aw_f, w_f, b_f, ar_f, r_f;

    task automatic rand_cycle(input bit stop);
        logic [31:0] ea;
        // registered status against the model
        check("r_pending_wr", pending_wr, exp_wr);
        check("r_pending_rd", pending_rd, exp_rd);
        check("r_idle", idle, (exp_wr == 0 && exp_rd == 0 && aw_q.size() == 0 && ar_q.size() == 0));
        check("r_err", err, err_m);
        check("r_err_id", err_id, err_id_m);
        // retire whatever handshook on the last edge, then offer new traffic
        if (aw_f) s_axi_awvalid = 1'b0;
        if (w_f)  s_axi_wvalid  = 1'b0;
        if (b_f)  m_axi_bvalid  = 1'b0;
        if (ar_f) s_axi_arvalid = 1'b0;
        if (r_f)  m_axi_rvalid  = 1'b0;
        if ($urandom_range(0, 15) == 0) mem_base = {$urandom, $urandom};
        drain = stop ? 1'b0 : ($urandom_range(0, 7) == 0);
        if (!s_axi_awvalid && !stop && $urandom_range(0, 2) == 0) begin
            s_axi_awvalid = 1'b1;
            s_axi_awaddr  = $urandom;
            s_axi_awid    = 16'($urandom);
        end
        if (!s_axi_wvalid && w_sent < aw_sent + 2 && $urandom_range(0, 1) == 0) begin
            s_axi_wvalid = 1'b1;
            s_axi_wdata  = {16{$urandom}};
            s_axi_wstrb  = {2{$urandom}};
        end
        if (!s_axi_arvalid && !stop && $urandom_range(0, 2) == 0) begin
            s_axi_arvalid = 1'b1;
            s_axi_araddr  = $urandom;
            s_axi_arid    = 16'($urandom);
            s_axi_arlen   = 8'($urandom_range(0, 3));
        end
        if (!m_axi_bvalid && b_q.size() != 0 && $urandom_range(0, 1) == 0) begin
            m_axi_bvalid = 1'b1;
            m_axi_bid    = b_q.pop_front();
            m_axi_bresp  = ($urandom_range(0, 31) == 0) ? 2'd2 : 2'd0;
        end
        if (!m_axi_rvalid && r_left == 0 && r_q.size() != 0) begin
            r_cur_id = r_q[0][23:8];
            r_left   = int'(r_q[0][7:0]) + 1;
            void'(r_q.pop_front());
        end
        if (!m_axi_rvalid && r_left != 0 && $urandom_range(0, 1) == 0) begin
            m_axi_rvalid = 1'b1;
            m_axi_rid    = r_cur_id;
            m_axi_rlast  = (r_left == 1);
            m_axi_rdata  = {16{$urandom}};
            m_axi_rresp  = ($urandom_range(0, 31) == 0) ? 2'd3 : 2'd0;
        end
        m_axi_awready = 1'($urandom_range(0, 1));
        m_axi_arready = 1'($urandom_range(0, 1));
        m_axi_wready  = 1'($urandom_range(0, 1));
        s_axi_bready  = 1'($urandom_range(0, 1));
        s_axi_rready  = 1'($urandom_range(0, 1));
        #1;
        check("r_awready", s_axi_awready, (aw_q.size() < 2 && !drain && exp_wr != 64));
        check("r_arready", s_axi_arready, (ar_q.size() < 2 && !drain && exp_rd != 64));
        check("r_m_awvalid", m_axi_awvalid, (aw_q.size() != 0));
        check("r_m_arvalid", m_axi_arvalid, (ar_q.size() != 0));
        if (aw_q.size() != 0) check("r_m_aw_payload", {m_axi_awid, m_axi_awaddr}, aw_q[0]);
        if (ar_q.size() != 0) check("r_m_ar_payload", {m_axi_arlen, m_axi_arid, m_axi_araddr}, ar_q[0]);
        check("r_w_pass", {m_axi_wvalid, s_axi_wready, m_axi_wdata}, {s_axi_wvalid, m_axi_wready, s_axi_wdata});
        check("r_b_pass", {s_axi_bvalid, m_axi_bready, s_axi_bid}, {m_axi_bvalid, s_axi_bready, m_axi_bid});
        check("r_r_pass", {s_axi_rvalid, s_axi_rlast, s_axi_rdata}, {m_axi_rvalid, m_axi_rlast, m_axi_rdata});
        // model update for the coming edge
        aw_f = s_axi_awvalid && s_axi_awready;
        w_f  = s_axi_wvalid && m_axi_wready;
        b_f  = m_axi_bvalid && s_axi_bready;
        ar_f = s_axi_arvalid && s_axi_arready;
        r_f  = m_axi_rvalid && s_axi_rready;
        if (m_axi_awvalid && m_axi_awready) b_q.push_back(aw_q.pop_front() >> 32);
        if (m_axi_arvalid && m_axi_arready) begin
            r_q.push_back({ar_q[0][47:32], ar_q[0][55:48]});
            void'(ar_q.pop_front());
        end
        if (aw_f) begin
            ea = s_axi_awaddr + mem_base[31:0];
            aw_q.push_back({s_axi_awid, ea});
            exp_wr++;
            aw_sent++;
        end
        if (ar_f) begin
            ea = s_axi_araddr + mem_base[31:0];
            ar_q.push_back({s_axi_arlen, s_axi_arid, ea});
            exp_rd++;
        end
        if (w_f) w_sent++;
        if (b_f) exp_wr--;
        if (r_f) r_left--;
        if (r_f && m_axi_rlast) exp_rd--;
        if (!err_m && b_f && m_axi_bresp != 2'd0) begin
            err_m = 1'b1; err_id_m = m_axi_bid;
        end else if (!err_m && r_f && m_axi_rresp != 2'd0) begin
            err_m = 1'b1; err_id_m = m_axi_rid;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; drain = 1'b0; mem_base = 64'd0;
        s_axi_awvalid = 1'b0; s_axi_awaddr = 32'd0; s_axi_awid = 16'd0;
        s_axi_wvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b1;
        s_axi_bready = 1'b0;
        s_axi_arvalid = 1'b0; s_axi_araddr = 32'd0; s_axi_arid = 16'd0; s_axi_arlen = 8'd0;
        s_axi_rready = 1'b0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
        m_axi_bvalid = 1'b0; m_axi_bid = 16'd0; m_axi_bresp = 2'd0;
        m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rlast = 1'b0; m_axi_rid = 16'd0; m_axi_rresp = 2'd0;
        tick(); tick();
        reset = 1'b0;
        #1;
        // reset state
        check("rst_m_awvalid", m_axi_awvalid, 0);
        check("rst_m_arvalid", m_axi_arvalid, 0);
        check("rst_pending", {pending_wr, pending_rd}, 0);
        check("rst_idle", idle, 1);
        check("rst_err", {err, err_id}, 0);

        // 1: rebased write, one-cycle latency, B clears pending
        mem_base = 64'h1000_0000;
        s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h40; s_axi_awid = 16'd5;
        #1;
        check("t1_awready", s_axi_awready, 1);
        check("t1_awvalid_pre", m_axi_awvalid, 0);
        tick();
        s_axi_awvalid = 1'b0;
        #1;
        check("t1_awvalid", m_axi_awvalid, 1);
        check("t1_awaddr", m_axi_awaddr, 32'h1000_0040);
        check("t1_awid", m_axi_awid, 5);
        check("t1_awlen", m_axi_awlen, 0);
        check("t1_pending_wr", pending_wr, 1);
        check("t1_idle_busy", idle, 0);
        m_axi_awready = 1'b1;
        s_axi_wvalid = 1'b1; s_axi_wdata = {16{32'hA5A5_0001}}; s_axi_wstrb = {64{1'b1}}; m_axi_wready = 1'b1;
        #1;
        check("t1_w_pass", {m_axi_wvalid, s_axi_wready, m_axi_wlast, m_axi_wstrb, m_axi_wdata},
              {1'b1, 1'b1, 1'b1, {64{1'b1}}, {16{32'hA5A5_0001}}});
        tick();
        m_axi_awready = 1'b0; s_axi_wvalid = 1'b0; m_axi_wready = 1'b0;
        m_axi_bvalid = 1'b1; m_axi_bid = 16'd5; m_axi_bresp = 2'd0; s_axi_bready = 1'b1;
        #1;
        check("t1_awvalid_done", m_axi_awvalid, 0);
        check("t1_b_pass", {s_axi_bvalid, m_axi_bready, s_axi_bid}, {1'b1, 1'b1, 16'd5});
        tick();
        m_axi_bvalid = 1'b0; s_axi_bready = 1'b0;
        #1;
        check("t1_pending_wr_0", pending_wr, 0);
        check("t1_idle", idle, 1);

        // 2: read cap at 64 outstanding, one RLAST frees a slot
        mem_base = 64'd0; m_axi_arready = 1'b1; s_axi_arvalid = 1'b1; s_axi_arlen = 8'd0;
        for (int i = 0; i < 64; i++) begin
            s_axi_araddr = 32'(i * 64);
            #1;
            check("t2_arready_full_rate", s_axi_arready, 1);
            tick();
        end
        #1;
        check("t2_arready_cap", s_axi_arready, 0);
        check("t2_pending_64", pending_rd, 64);
        s_axi_arvalid = 1'b0;
        m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1; m_axi_rid = 16'd0; m_axi_rresp = 2'd0;
        m_axi_rdata = {8{64'hDEAD_BEEF_0123_4567}}; s_axi_rready = 1'b1;
        #1;
        check("t2_r_pass", {s_axi_rvalid, m_axi_rready, s_axi_rlast, s_axi_rdata},
              {1'b1, 1'b1, 1'b1, {8{64'hDEAD_BEEF_0123_4567}}});
        tick();
        m_axi_rvalid = 1'b0;
        #1;
        check("t2_pending_63", pending_rd, 63);
        check("t2_arready_back", s_axi_arready, 1);
        m_axi_rvalid = 1'b1;
        for (int i = 0; i < 63; i++) tick();
        m_axi_rvalid = 1'b0; s_axi_rready = 1'b0; m_axi_arready = 1'b0;
        #1;
        check("t2_drained", {pending_rd, idle}, {7'd0, 1'b1});

        // 3: address wrap, upper base bits ignored, arlen forwarded
        mem_base = 64'hABCD_0000_FFFF_FFF0;
        s_axi_arvalid = 1'b1; s_axi_araddr = 32'h20; s_axi_arid = 16'h1234; s_axi_arlen = 8'd3;
        tick();
        s_axi_arvalid = 1'b0;
        #1;
        check("t3_araddr_wrap", m_axi_araddr, 32'h0000_0010);
        check("t3_ar_fields", {m_axi_arvalid, m_axi_arid, m_axi_arlen}, {1'b1, 16'h1234, 8'd3});
        m_axi_arready = 1'b1;
        tick();
        m_axi_arready = 1'b0;
        m_axi_rvalid = 1'b1; m_axi_rlast = 1'b0; m_axi_rid = 16'h1234; s_axi_rready = 1'b1;
        tick(); tick(); tick();
        #1;
        check("t3_nonlast_hold", pending_rd, 1);
        m_axi_rlast = 1'b1;
        tick();
        m_axi_rvalid = 1'b0; s_axi_rready = 1'b0;
        #1;
        check("t3_pending_rd_0", pending_rd, 0);

        // 4: simultaneous AW/B holds count; drain keeps presented request
        mem_base = 64'd0; m_axi_awready = 1'b1; s_axi_awvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_axi_awaddr = 32'(i); s_axi_awid = 16'(i);
            tick();
        end
        s_axi_awvalid = 1'b0;
        tick();
        #1;
        check("t4_pending_3", {pending_wr, m_axi_awvalid}, {7'd3, 1'b0});
        m_axi_awready = 1'b0; mem_base = 64'h2000;
        s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h80; s_axi_awid = 16'd2;
        m_axi_bvalid = 1'b1; m_axi_bid = 16'd0; m_axi_bresp = 2'd0; s_axi_bready = 1'b1;
        tick();
        m_axi_bvalid = 1'b0; s_axi_bready = 1'b0; drain = 1'b1; mem_base = 64'h0;
        #1;
        check("t4_hold_count", pending_wr, 3);
        check("t4_drain_blocks", s_axi_awready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_stable", {m_axi_awvalid, m_axi_awid, m_axi_awaddr}, {1'b1, 16'd2, 32'h2080});
        end
        m_axi_awready = 1'b1;
        tick();
        m_axi_awready = 1'b0; s_axi_awvalid = 1'b0;
        #1;
        check("t4_accepted", {m_axi_awvalid, pending_wr}, {1'b0, 7'd3});
        drain = 1'b0;
        m_axi_bvalid = 1'b1; s_axi_bready = 1'b1;
        tick(); tick(); tick();
        m_axi_bvalid = 1'b0; s_axi_bready = 1'b0;
        #1;
        check("t4_idle", {pending_wr, idle}, {7'd0, 1'b1});

        // 5: sticky error keeps first id; reset discards buffered reads
        m_axi_awready = 1'b1; m_axi_arready = 1'b1;
        s_axi_awvalid = 1'b1; s_axi_arvalid = 1'b1; s_axi_arlen = 8'd0;
        tick();
        s_axi_awvalid = 1'b0; s_axi_arvalid = 1'b0;
        tick();
        m_axi_bvalid = 1'b1; m_axi_bid = 16'd7; m_axi_bresp = 2'd2; s_axi_bready = 1'b1;
        tick();
        m_axi_bvalid = 1'b0;
        #1;
        check("t5_err_b", {err, err_id}, {1'b1, 16'd7});
        m_axi_rvalid = 1'b1; m_axi_rid = 16'd9; m_axi_rresp = 2'd3; m_axi_rlast = 1'b1; s_axi_rready = 1'b1;
        tick();
        m_axi_rvalid = 1'b0;
        #1;
        check("t5_err_keep", {err, err_id, pending_wr, pending_rd}, {1'b1, 16'd7, 7'd0, 7'd0});
        m_axi_arready = 1'b0; m_axi_awready = 1'b0; s_axi_arvalid = 1'b1;
        tick(); tick();
        #1;
        check("t5_ar_full", {s_axi_arready, m_axi_arvalid, pending_rd, idle}, {1'b0, 1'b1, 7'd2, 1'b0});
        s_axi_arvalid = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("t5_reset", {m_axi_arvalid, pending_rd, idle, err, err_id}, {1'b0, 7'd0, 1'b1, 1'b0, 16'd0});

        // B and R erroring on the same edge: B id wins
        m_axi_awready = 1'b1; m_axi_arready = 1'b1; s_axi_awvalid = 1'b1; s_axi_arvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0; s_axi_arvalid = 1'b0;
        tick();
        m_axi_bvalid = 1'b1; m_axi_bid = 16'd3; m_axi_bresp = 2'd1; s_axi_bready = 1'b1;
        m_axi_rvalid = 1'b1; m_axi_rid = 16'd4; m_axi_rresp = 2'd2; m_axi_rlast = 1'b1; s_axi_rready = 1'b1;
        tick();
        m_axi_bvalid = 1'b0; m_axi_rvalid = 1'b0;
        #1;
        check("t5_b_wins", {err, err_id, pending_wr, pending_rd}, {1'b1, 16'd3, 7'd0, 7'd0});
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // 6: randomized traffic with backpressure against the model
        exp_wr = 0; exp_rd = 0; r_left = 0; r_cur_id = 16'd0; err_m = 1'b0; err_id_m = 16'd0;
        aw_sent = 0; w_sent = 0;
        aw_f = 1'b0; w_f = 1'b0; b_f = 1'b0; ar_f = 1'b0; r_f = 1'b0;
        for (int c = 0; c < 10000; c++) rand_cycle(1'b0);
        for (int c = 0; c < 3000; c++) begin
            if (exp_wr == 0 && exp_rd == 0 && aw_q.size() == 0 && ar_q.size() == 0 &&
                b_q.size() == 0 && r_q.size() == 0 && r_left == 0 && !s_axi_wvalid &&
                !s_axi_awvalid && !s_axi_arvalid && !m_axi_bvalid && !m_axi_rvalid) break;
            rand_cycle(1'b1);
        end
        check("t6_drain_outstanding", exp_wr + exp_rd + aw_q.size() + ar_q.size(), 0);
        check("t6_end_idle", {idle, pending_wr, pending_rd}, {1'b1, 7'd0, 7'd0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
